// File: rtl/jk_flipflop.sv
// jk_flipflop: bank of WIDTH independent JK flip-flops with true and complementary outputs.
// Optional simulation X-checking of J/K is enabled by defining JK_FLIPFLOP_XCHECK_EN.
module jk_flipflop #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar
);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_next_s;

   // An X/Z pair matches no listed item, so the default keeps the old value (hold).
   function automatic logic jk_next(input logic j, input logic k, input logic q);
      logic n;
      case ({j, k})
         2'b00:   n = q;
         2'b01:   n = 1'b0;
         2'b10:   n = 1'b1;
         2'b11:   n = ~q;
         default: n = q;
      endcase
      return n;
   endfunction

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
`ifdef JK_FLIPFLOP_XCHECK_EN
      assign q_next_s[g] = $isunknown({J[g], K[g]}) ? 1'bx : jk_next(J[g], K[g], q_r[g]);
`else
      assign q_next_s[g] = jk_next(J[g], K[g], q_r[g]);
`endif
   end

   // State register with asynchronous reset to RESET_VALUE
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_r <= RESET_VALUE;
      end else begin
         q_r <= q_next_s;
      end
   end

`ifdef JK_FLIPFLOP_XCHECK_EN
   // Simulation-only warning for unknown J/K at a clock edge
   always @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if ($isunknown({J[i], K[i]})) begin
               $display("%0t jk_flipflop: unknown J/K on bit %0d", $time, i);
            end
         end
      end
   end
`endif

   assign Q    = q_r;
   assign Qbar = ~q_r;

endmodule

// File: tb/tb_jk_flipflop.sv
// Self-checking bench for jk_flipflop: directed steps plus randomized J/K/reset
// against a behavioural JK model, on a 1-bit and a 4-bit instance.
module tb_jk_flipflop;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, j1, k1, q1, qb1;
   logic       rst4;
   logic [3:0] j4, k4, q4, qb4;

   int         total = 0;
   int         bad   = 0;
   logic       m1;
   logic [3:0] m4;

   localparam logic [3:0] RV4 = 4'b1010;

   jk_flipflop #(.WIDTH(1)) dut1 (
      .CLK(clk), .RST(rst1), .J(j1), .K(k1), .Q(q1), .Qbar(qb1)
   );

   jk_flipflop #(.WIDTH(4), .RESET_VALUE(RV4)) dut4 (
      .CLK(clk), .RST(rst4), .J(j4), .K(k4), .Q(q4), .Qbar(qb4)
   );

   // Behavioural JK rule: set wins alone, reset wins alone, both toggles, neither holds
   function automatic logic jk_rule(input logic j, input logic k, input logic q);
      if (j && k) return !q;
      if (j)      return 1'b1;
      if (k)      return 1'b0;
      return q;
   endfunction

   function automatic logic [3:0] jk_rule4(input logic [3:0] j, input logic [3:0] k,
                                           input logic [3:0] q);
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = jk_rule(j[b], k[b], q[b]);
      return r;
   endfunction

   task automatic chk1(input string tag);
      total++;
      assert ({q1, qb1} === {m1, ~m1})
      else begin
         bad++;
         $error("FAIL %s: Q=%b Qbar=%b expected Q=%b Qbar=%b", tag, q1, qb1, m1, ~m1);
      end
   endtask

   task automatic chk4(input string tag);
      total++;
      assert ({q4, qb4} === {m4, ~m4})
      else begin
         bad++;
         $error("FAIL %s: Q=%b Qbar=%b expected Q=%b Qbar=%b", tag, q4, qb4, m4, ~m4);
      end
   endtask

   // One rising edge: advance the models from the inputs present at the edge
   task automatic step();
      @(posedge clk);
      m1 = rst1 ? 1'b0 : jk_rule(j1, k1, m1);
      m4 = rst4 ? RV4  : jk_rule4(j4, k4, m4);
      #1;
   endtask

   initial begin
      rst1 = 1'b1; rst4 = 1'b1;
      j1 = 1'b0; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
      m1 = 1'b0; m4 = RV4;
      #2;
      chk1("reset_before_edge");
      chk4("reset4_before_edge");
      #1;
      rst1 = 1'b0; rst4 = 1'b0;

      for (int n = 0; n < 3; n++) begin
         step();
         chk1("hold_after_reset");
      end

      j1 = 1'b1; k1 = 1'b0; step(); chk1("set");
      if (q1 !== 1'b1) $display("note: set step did not reach 1");
      j1 = 1'b0; k1 = 1'b1; step(); chk1("clear");

      j1 = 1'b1; k1 = 1'b1;
      for (int n = 0; n < 4; n++) begin
         step();
         chk1("toggle");
      end

      j1 = 1'b1; k1 = 1'b0; step(); chk1("set_before_reset");
      j1 = 1'b1; k1 = 1'b1;
      #2;
      rst1 = 1'b1; m1 = 1'b0;
      #1;
      chk1("async_reset_immediate");
      j1 = 1'b1; k1 = 1'b0;
      step(); chk1("edge_during_reset");
      rst1 = 1'b0;
      step(); chk1("first_edge_after_reset");

      j4 = 4'b0011; k4 = 4'b0101;
      step(); chk4("width4_mixed");
      total++;
      assert (q4 === 4'b1011)
      else begin
         bad++;
         $error("FAIL width4_const: Q=%b expected Q=%b", q4, 4'b1011);
      end

      for (int n = 0; n < 80; n++) begin
         j1 = 1'($urandom); k1 = 1'($urandom);
         j4 = 4'($urandom); k4 = 4'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            rst4 = 1'b1; m4 = RV4;
            #1;
            chk4("rand_async_reset4");
            rst4 = 1'b0;
         end
         step();
         chk1("rand_w1");
         chk4("rand_w4");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
